fetch_unit: RTL

- Instruction fetch stage that produces the 16-bit instruction words consumed by the decode/control logic.
- Maintains the PC and reads instruction memory over a request/valid handshake.
- Assembles two-word instructions (opcode word plus immediate word).
- Presents each instruction to decode with a valid/stall handshake; flushes on taken branches.

---
 rtl/isa_pkg.sv | 25 ++
 rtl/instr_len_decode.sv | 11 +
 rtl/fetch_unit.sv | 102 ++++++++++
 3 files changed

// File: rtl/isa_pkg.sv
// Shared ISA definitions: opcode field, opcode constants and fetch FSM states.
package isa_pkg;

  localparam int OPC_HI = 15;
  localparam int OPC_LO = 11;
  localparam int OPC_W  = OPC_HI - OPC_LO + 1;

  localparam logic [OPC_W-1:0] OP_NOP = 5'b00000;
  localparam logic [OPC_W-1:0] OP_IMM = 5'b00001;  // memory-read / immediate-source
  localparam logic [OPC_W-1:0] OP_ALU = 5'b00010;
  localparam logic [OPC_W-1:0] OP_JMP = 5'b00011;

  typedef enum logic [1:0] {
    IDLE,
    FETCH_OP,
    FETCH_IMM,
    ISSUE
  } fetchState_t;

  // Only the immediate-source opcode carries a second (immediate) word.
  function automatic logic isTwoWord(input logic [OPC_W-1:0] opCode);
    return opCode == OP_IMM;
  endfunction

endpackage

// File: rtl/instr_len_decode.sv
// Instruction length decode: flags opcodes that are followed by an immediate word.
module instr_len_decode
  import isa_pkg::*;
(
  input  logic [OPC_W-1:0] opCode,
  output logic             twoWord
);

  assign twoWord = isTwoWord(opCode);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, memory read handshake, two-word assembly and
// issue to decode with stall hold and branch flush.
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | just out of reset; one cycle before the first fetch
// FETCH_OP  | reading the opcode word at pc
// FETCH_IMM | reading the immediate word of a two-word instruction
// ISSUE     | instruction presented to decode, held while stalled
module fetch_unit
  import isa_pkg::*;
#(
  parameter int                ADDR_W   = 16,
  parameter int                INSTR_W  = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_rd,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  input  logic               imem_valid,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic [INSTR_W-1:0] instr_out,
  output logic [INSTR_W-1:0] imm_out,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               instr_valid
);

  fetchState_t        state;
  logic [ADDR_W-1:0]  pc;
  logic [INSTR_W-1:0] opWord;
  logic               twoWord;

  instr_len_decode uLenDecode (
    .opCode  (imem_data[OPC_HI:OPC_LO]),
    .twoWord (twoWord)
  );

  // Memory request is a pure decode of state, so reset drops it immediately.
  assign imem_rd   = (state == FETCH_OP) || (state == FETCH_IMM);
  assign imem_addr = pc;

  // Fetch FSM, PC and registered issue outputs; a branch outranks everything but IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      opWord      <= '0;
      instr_out   <= '0;
      imm_out     <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
    end else if (state == IDLE) begin
      state <= FETCH_OP;
    end else if (branch_taken) begin
      pc          <= branch_target;
      opWord      <= '0;
      instr_valid <= 1'b0;
      state       <= FETCH_OP;
    end else begin
      case (state)
        FETCH_OP: begin
          if (imem_valid) begin
            opWord   <= imem_data;
            instr_pc <= pc;
            pc       <= pc + 1'b1;
            if (twoWord) begin
              state <= FETCH_IMM;
            end else begin
              instr_out   <= imem_data;
              imm_out     <= '0;
              instr_valid <= 1'b1;
              state       <= ISSUE;
            end
          end
        end
        FETCH_IMM: begin
          if (imem_valid) begin
            imm_out     <= imem_data;
            instr_out   <= opWord;
            pc          <= pc + 1'b1;
            instr_valid <= 1'b1;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          if (!stall) begin
            instr_valid <= 1'b0;
            state       <= FETCH_OP;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
